// File: rtl/usb_pkg.sv
// Shared constants and types for the full-speed USB receive path:
// PID bytes, packet-type encoding, CRC16 parameters, line states, FSM states.
package usb_pkg;

  // PID bytes as assembled LSB-first off the wire
  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  // KJKJKJKK decodes to 0,0,0,0,0,0,0,1 in time order
  localparam logic [7:0] SYNC_BYTE = 8'h80;

  localparam logic [15:0] CRC16_POLY  = 16'h8005;
  localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
  localparam logic [15:0] CRC16_RESID = 16'h800D;

  typedef enum logic [2:0] {
    PKT_NONE, PKT_OUT, PKT_IN, PKT_DATA0, PKT_DATA1, PKT_ACK, PKT_NAK, PKT_STALL
  } rx_pkt_t;

  // {D+, D-}
  typedef enum logic [1:0] {
    LINE_SE0 = 2'b00, LINE_K = 2'b01, LINE_J = 2'b10, LINE_SE1 = 2'b11
  } line_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_SYNC, RX_PID, RX_PAYLOAD, RX_EOP_WAIT, RX_ERR
  } rx_state_t;

  function automatic rx_pkt_t pid_decode(input logic [7:0] pid);
    rx_pkt_t p;
    p = PKT_NONE;
    if (pid[7:4] == ~pid[3:0]) begin
      case (pid)
        PID_OUT:   p = PKT_OUT;
        PID_IN:    p = PKT_IN;
        PID_DATA0: p = PKT_DATA0;
        PID_DATA1: p = PKT_DATA1;
        PID_ACK:   p = PKT_ACK;
        PID_NAK:   p = PKT_NAK;
        PID_STALL: p = PKT_STALL;
        default:   p = PKT_NONE;
      endcase
    end
    return p;
  endfunction

  // Serial CRC16, bits fed in wire order, MSB-first register
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    return {crc[14:0], 1'b0} ^ ((crc[15] ^ b) ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/rx_bit_decoder.sv
// Line front end: synchronizers, edge-aligned phase counter, NRZI decode and
// bit unstuffing. Outputs are single-clk strobes at the mid-bit sample point.
module rx_bit_decoder
  import usb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic dPlus_in,
  input  logic dMinus_in,
  input  logic unstuff_en,
  output logic bit_valid,
  output logic bit_value,
  output logic stuff_err,
  output logic se0,
  output logic j_idle
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    dp_sync, dm_sync;
  logic [1:0]    line_s, line_q;
  logic [CW-1:0] phase;
  logic          prev_dp;
  logic [2:0]    ones;
  logic          sample, line_se0, raw_bit, stuffed;

  assign line_s   = {dp_sync[1], dm_sync[1]};
  assign sample   = (phase == HALF);
  assign line_se0 = (line_q == LINE_SE0);
  assign raw_bit  = (line_q[1] == prev_dp);
  // Ones run is held cleared while idle so long J periods never mark the SOP K as stuffing
  assign stuffed  = unstuff_en && (ones == 3'd6);

  assign bit_valid = sample && !line_se0 && !stuffed;
  assign bit_value = raw_bit;
  assign stuff_err = sample && !line_se0 && stuffed && raw_bit;
  assign se0       = sample && line_se0;
  assign j_idle    = sample && (line_q == LINE_J);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_sync <= 2'b11;
      dm_sync <= 2'b00;
      line_q  <= LINE_J;
      phase   <= '0;
      prev_dp <= 1'b1;
      ones    <= 3'd0;
    end else begin
      dp_sync <= {dp_sync[0], dPlus_in};
      dm_sync <= {dm_sync[0], dMinus_in};
      line_q  <= line_s;
      if (line_s != line_q) phase <= '0;
      else                  phase <= (phase == LAST) ? '0 : phase + 1'b1;
      if (sample) begin
        if (line_se0) begin
          // A J following SE0 must decode as 1, never as a fresh SOP edge
          prev_dp <= 1'b1;
          ones    <= 3'd0;
        end else begin
          prev_dp <= line_q[1];
          if (!unstuff_en || stuffed) ones <= 3'd0;
          else                        ones <= raw_bit ? ones + 3'd1 : 3'd0;
        end
      end
    end
  end

endmodule

// File: rtl/usb_rx.sv
// Full-speed USB receive path: packet FSM, 2-byte holdback buffer that hides
// CRC/token trailer bytes, and CRC16 residual check on data packets.
module usb_rx
  import usb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int MAX_BYTES    = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       dPlus_in,
  input  logic       dMinus_in,
  output logic [2:0] rx_packet,
  output logic [7:0] rx_data,
  output logic       store_rx_packet_data,
  output logic       rx_transfer_active,
  output logic       rx_done,
  output logic       rx_error
);
  localparam int BCW = $clog2(MAX_BYTES + 3);
  localparam logic [BCW-1:0] CNT_LIMIT = BCW'(MAX_BYTES + 2);

  rx_state_t      state, state_n;
  rx_pkt_t        pkt_q, pid_pkt;
  logic           bit_valid, bit_value, stuff_err, se0, j_idle;
  logic [7:0]     sh, hold0, hold1, byte_val;
  logic [2:0]     bit_cnt;
  logic [BCW-1:0] rcv_cnt;
  logic [15:0]    crc;
  logic [1:0]     se0_cnt;
  logic           byte_done, shift_en, pkt_is_data, pid_is_hs;
  logic           sop, pid_take, push, done_set, err_enter;

  rx_bit_decoder #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_dec (
    .clk        (clk),
    .n_rst      (n_rst),
    .dPlus_in   (dPlus_in),
    .dMinus_in  (dMinus_in),
    .unstuff_en (state != RX_IDLE),
    .bit_valid  (bit_valid),
    .bit_value  (bit_value),
    .stuff_err  (stuff_err),
    .se0        (se0),
    .j_idle     (j_idle)
  );

  assign byte_val    = {bit_value, sh[7:1]};
  assign byte_done   = bit_valid && (bit_cnt == 3'd7);
  assign pid_pkt     = pid_decode(byte_val);
  assign pid_is_hs   = (pid_pkt == PKT_ACK) || (pid_pkt == PKT_NAK) || (pid_pkt == PKT_STALL);
  assign pkt_is_data = (pkt_q == PKT_DATA0) || (pkt_q == PKT_DATA1);
  assign shift_en    = sop || (bit_valid && (state == RX_SYNC || state == RX_PID ||
                                             state == RX_PAYLOAD));
  assign err_enter   = (state_n == RX_ERR) && (state != RX_ERR);
  assign rx_packet   = pkt_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= RX_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    sop      = 1'b0;
    pid_take = 1'b0;
    push     = 1'b0;
    done_set = 1'b0;
    case (state)
      RX_IDLE:
        if (bit_valid && !bit_value) begin
          sop     = 1'b1;
          state_n = RX_SYNC;
        end
      RX_SYNC:
        if (se0 || stuff_err) state_n = RX_ERR;
        else if (byte_done)   state_n = (byte_val == SYNC_BYTE) ? RX_PID : RX_ERR;
      RX_PID:
        if (se0 || stuff_err) state_n = RX_ERR;
        else if (byte_done) begin
          if (pid_pkt == PKT_NONE) state_n = RX_ERR;
          else begin
            pid_take = 1'b1;
            state_n  = pid_is_hs ? RX_EOP_WAIT : RX_PAYLOAD;
          end
        end
      RX_PAYLOAD:
        if (stuff_err) state_n = RX_ERR;
        else if (se0)  state_n = (bit_cnt == 3'd0) ? RX_EOP_WAIT : RX_ERR;
        else if (byte_done) begin
          if (pkt_is_data && rcv_cnt == CNT_LIMIT) state_n = RX_ERR;
          else                                     push    = 1'b1;
        end
      RX_EOP_WAIT:
        // Any non-SE0 sample here either closes the EOP or is a stray bit
        if (j_idle) begin
          if (se0_cnt >= 2'd2 && !(pkt_is_data && crc != CRC16_RESID)) begin
            done_set = 1'b1;
            state_n  = RX_IDLE;
          end else state_n = RX_ERR;
        end else if (bit_valid || stuff_err) state_n = RX_ERR;
      RX_ERR:
        if (j_idle && se0_cnt != 2'd0) state_n = RX_IDLE;
      default: state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pkt_q                <= PKT_NONE;
      rx_data              <= 8'h00;
      store_rx_packet_data <= 1'b0;
      rx_transfer_active   <= 1'b0;
      rx_done              <= 1'b0;
      rx_error             <= 1'b0;
      sh                   <= 8'h00;
      hold0                <= 8'h00;
      hold1                <= 8'h00;
      bit_cnt              <= 3'd0;
      rcv_cnt              <= '0;
      crc                  <= CRC16_INIT;
      se0_cnt              <= 2'd0;
    end else begin
      store_rx_packet_data <= 1'b0;
      rx_done              <= done_set;
      rx_transfer_active   <= (state_n != RX_IDLE);
      if (shift_en) begin
        sh      <= byte_val;
        bit_cnt <= sop ? 3'd1 : bit_cnt + 3'd1;
      end
      // se0_cnt doubles as the "EOP SE0 seen" flag for leaving RX_ERR
      if (se0 && se0_cnt != 2'd3) se0_cnt <= se0_cnt + 2'd1;
      if (sop) begin
        pkt_q    <= PKT_NONE;
        rx_error <= 1'b0;
        se0_cnt  <= 2'd0;
      end
      if (err_enter) rx_error <= 1'b1;
      if (pid_take) begin
        pkt_q   <= pid_pkt;
        crc     <= CRC16_INIT;
        rcv_cnt <= '0;
      end else if (state == RX_PAYLOAD && bit_valid) begin
        crc <= crc16_step(crc, bit_value);
      end
      if (push) begin
        hold1 <= byte_val;
        hold0 <= hold1;
        if (rcv_cnt != CNT_LIMIT) rcv_cnt <= rcv_cnt + BCW'(1);
        if (rcv_cnt >= BCW'(2)) begin
          rx_data              <= hold0;
          store_rx_packet_data <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_usb_rx.sv
// Directed bench for usb_rx: NRZI/bit-stuffing line driver, strobe/done
// monitor, and hand-picked packets with expected outputs.
module tb_usb_rx;
  localparam int CPB  = 8;
  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       dp, dm;
  logic [2:0] rx_packet;
  logic [7:0] rx_data;
  logic       store_rx_packet_data, rx_transfer_active, rx_done, rx_error;

  int         n_chk = 0;
  int         n_err = 0;
  int         done_cnt;
  int         ones;
  logic       lvl;
  logic [7:0] rxq[$];
  logic [7:0] pay[0:7];

  always #5 clk = ~clk;

  usb_rx #(.CLKS_PER_BIT(CPB), .MAX_BYTES(MAXB)) dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .dPlus_in             (dp),
    .dMinus_in            (dm),
    .rx_packet            (rx_packet),
    .rx_data              (rx_data),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_transfer_active   (rx_transfer_active),
    .rx_done              (rx_done),
    .rx_error             (rx_error)
  );

  always @(negedge clk) begin
    if (store_rx_packet_data) rxq.push_back(rx_data);
    if (rx_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input int i);
    return (rxq.size() > i) ? {24'h0, rxq[i]} : 32'hDEAD;
  endfunction

  task automatic drive(input logic [1:0] ln, input int nbits);
    {dp, dm} = ln;
    repeat (nbits * CPB) @(negedge clk);
  endtask

  task automatic tx_bit(input logic b);
    if (!b) lvl = ~lvl;
    drive(lvl ? 2'b10 : 2'b01, 1);
    if (b) begin
      ones++;
      if (ones == 6) begin
        lvl = ~lvl;
        drive(lvl ? 2'b10 : 2'b01, 1);
        ones = 0;
      end
    end else ones = 0;
  endtask

  task automatic tx_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) tx_bit(b[i]);
  endtask

  task automatic tx_start(input logic [7:0] pid);
    rxq.delete();
    done_cnt = 0;
    ones     = 0;
    lvl      = 1'b1;
    tx_byte(8'h80);
    tx_byte(pid);
  endtask

  task automatic tx_eop();
    drive(2'b00, 2);
    lvl = 1'b1;
    drive(2'b10, 5);
  endtask

  // Data packet from pay[0:n-1]; flip >= 0 inverts that CRC bit on the wire
  task automatic tx_data(input logic [7:0] pid, input int n, input int flip);
    logic [15:0] crc;
    logic        b;
    crc = 16'hFFFF;
    tx_start(pid);
    for (int k = 0; k < n; k++) begin
      tx_byte(pay[k]);
      for (int i = 0; i < 8; i++)
        crc = {crc[14:0], 1'b0} ^ ((crc[15] ^ pay[k][i]) ? 16'h8005 : 16'h0000);
    end
    for (int i = 15; i >= 0; i--) begin
      b = ~crc[i];
      if (i == flip) b = ~b;
      tx_bit(b);
    end
    tx_eop();
  endtask

  initial begin
    n_rst = 1'b0;
    {dp, dm} = 2'b10;
    done_cnt = 0;
    repeat (3) @(negedge clk);
    chk("rst_packet", rx_packet, 0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_store", store_rx_packet_data, 0);
    chk("rst_active", rx_transfer_active, 0);
    chk("rst_done", rx_done, 0);
    chk("rst_error", rx_error, 0);
    n_rst = 1'b1;
    drive(2'b10, 4);

    // ACK handshake
    tx_start(8'hD2);
    chk("ack_active_mid", rx_transfer_active, 1);
    tx_eop();
    chk("ack_packet", rx_packet, 5);
    chk("ack_done", done_cnt, 1);
    chk("ack_strobes", rxq.size(), 0);
    chk("ack_error", rx_error, 0);
    chk("ack_active_end", rx_transfer_active, 0);

    // DATA0 01 02 03
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
    tx_data(8'hC3, 3, -1);
    chk("d0_strobes", rxq.size(), 3);
    chk("d0_b0", q_at(0), 8'h01);
    chk("d0_b1", q_at(1), 8'h02);
    chk("d0_b2", q_at(2), 8'h03);
    chk("d0_packet", rx_packet, 3);
    chk("d0_done", done_cnt, 1);
    chk("d0_error", rx_error, 0);

    // DATA1 FF FF exercises unstuffing
    pay[0] = 8'hFF; pay[1] = 8'hFF;
    tx_data(8'h4B, 2, -1);
    chk("d1_strobes", rxq.size(), 2);
    chk("d1_b0", q_at(0), 8'hFF);
    chk("d1_b1", q_at(1), 8'hFF);
    chk("d1_packet", rx_packet, 4);
    chk("d1_done", done_cnt, 1);
    chk("d1_error", rx_error, 0);

    // DATA0 01 with a corrupted CRC bit
    pay[0] = 8'h01;
    tx_data(8'hC3, 1, 3);
    chk("crc_strobes", rxq.size(), 1);
    chk("crc_b0", q_at(0), 8'h01);
    chk("crc_error", rx_error, 1);
    chk("crc_done", done_cnt, 0);
    chk("crc_packet", rx_packet, 3);
    chk("crc_active", rx_transfer_active, 0);

    // Bad check nibble
    tx_start(8'hC2);
    repeat (2) @(negedge clk);
    chk("pid_error_early", rx_error, 1);
    chk("pid_active_mid", rx_transfer_active, 1);
    tx_eop();
    chk("pid_packet", rx_packet, 0);
    chk("pid_done", done_cnt, 0);
    chk("pid_active_end", rx_transfer_active, 0);

    // Handshake with a stray bit before SE0
    tx_start(8'hD2);
    tx_bit(1'b0);
    tx_eop();
    chk("hs_extra_error", rx_error, 1);
    chk("hs_extra_done", done_cnt, 0);

    // Payload exactly MAX_BYTES
    pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3; pay[3] = 8'hD4;
    tx_data(8'hC3, 4, -1);
    chk("max_strobes", rxq.size(), 4);
    chk("max_b3", q_at(3), 8'hD4);
    chk("max_done", done_cnt, 1);
    chk("max_error", rx_error, 0);

    // Payload one past MAX_BYTES
    pay[0] = 8'h10; pay[1] = 8'h20; pay[2] = 8'h30; pay[3] = 8'h40; pay[4] = 8'h50;
    tx_data(8'h4B, 5, -1);
    chk("ovf_strobes", rxq.size(), 4);
    chk("ovf_error", rx_error, 1);
    chk("ovf_done", done_cnt, 0);

    // Reset mid-payload, then a clean ACK
    tx_start(8'hC3);
    tx_byte(8'h55);
    tx_bit(1'b0); tx_bit(1'b1); tx_bit(1'b0);
    n_rst = 1'b0;
    @(negedge clk);
    chk("mrst_packet", rx_packet, 0);
    chk("mrst_active", rx_transfer_active, 0);
    chk("mrst_error", rx_error, 0);
    chk("mrst_store", store_rx_packet_data, 0);
    drive(2'b10, 2);
    n_rst = 1'b1;
    drive(2'b10, 4);
    tx_start(8'hD2);
    tx_eop();
    chk("mrst_ack_packet", rx_packet, 5);
    chk("mrst_ack_done", done_cnt, 1);
    chk("mrst_ack_error", rx_error, 0);
    chk("mrst_ack_strobes", rxq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
